// File: rtl/stage4_log2_approx_if.sv
// Operand/result bundle for the Mitchell log2 stage: enable, operand in,
// approximation plus realignment bypass out.
interface stage4_log2_approx_if;
   logic        i_en;
   logic        i_valid;
   logic [15:0] i_x;
   logic        o_valid;
   logic [15:0] o_log_x;
   logic [15:0] o_x_bypass;
   logic        o_invalid;

   modport master (
      output i_en, i_valid, i_x,
      input  o_valid, o_log_x, o_x_bypass, o_invalid
   );

   modport slave (
      input  i_en, i_valid, i_x,
      output o_valid, o_log_x, o_x_bypass, o_invalid
   );
endinterface

// File: rtl/stage4_log2_approx.sv
// Three-stage Mitchell log2 approximation, Q6.10 in/out; latency 3 enabled edges.
// No backpressure: i_en=0 freezes every stage, inputs are ignored while frozen.
module stage4_log2_approx #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   stage4_log2_approx_if.slave  bus
);
   localparam int MAG_W = DATA_W - 1;
   localparam int K_W   = 4;
   localparam int INT_W = DATA_W - FRAC_W;

   // S1: capture
   logic              vld1_q;
   logic              bad1_q, bad1_d;
   logic [DATA_W-1:0] x1_q;

   // S2: leading-one detect
   logic              vld2_q;
   logic              bad2_q;
   logic [DATA_W-1:0] x2_q;
   logic [K_W-1:0]    k2_q, k2_d;
   logic [FRAC_W-1:0] man2_q, man2_d;
   logic [MAG_W-1:0]  norm_c;

   // S3: assemble
   logic              vld3_q;
   logic              inv3_q;
   logic [DATA_W-1:0] x3_q;
   logic [DATA_W-1:0] log3_q, log3_d;
   logic [INT_W-1:0]  int_c;

   assign bad1_d = bus.i_x[DATA_W-1] | (bus.i_x == '0);

   always_comb begin
      k2_d = '0;
      for (int i = 0; i < MAG_W; i++) begin
         if (x1_q[i]) k2_d = K_W'(i);
      end
      norm_c = x1_q[MAG_W-1:0] << (K_W'(MAG_W - 1) - k2_d);
      // Drop the implicit leading one; bits below the kept field are truncated.
      man2_d = norm_c[MAG_W-2 -: FRAC_W];
   end

   always_comb begin
      int_c  = INT_W'(k2_q) - INT_W'(FRAC_W);
      log3_d = bad2_q ? {1'b1, {(DATA_W-1){1'b0}}} : {int_c, man2_q};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld1_q <= 1'b0;
         bad1_q <= 1'b0;
         x1_q   <= '0;
         vld2_q <= 1'b0;
         bad2_q <= 1'b0;
         x2_q   <= '0;
         k2_q   <= '0;
         man2_q <= '0;
         vld3_q <= 1'b0;
         inv3_q <= 1'b0;
         x3_q   <= '0;
         log3_q <= '0;
      end else if (bus.i_en) begin
         vld1_q <= bus.i_valid;
         bad1_q <= bad1_d;
         x1_q   <= bus.i_x;
         vld2_q <= vld1_q;
         bad2_q <= bad1_q;
         x2_q   <= x1_q;
         k2_q   <= k2_d;
         man2_q <= man2_d;
         vld3_q <= vld2_q;
         inv3_q <= bad2_q;
         x3_q   <= x2_q;
         log3_q <= log3_d;
      end
   end

   assign bus.o_valid    = vld3_q;
   assign bus.o_log_x    = log3_q;
   assign bus.o_x_bypass = x3_q;
   assign bus.o_invalid  = inv3_q;
endmodule

// File: tb/tb_stage4_log2_approx.sv
// Directed bench for stage4_log2_approx: scoreboard of expected results keyed
// by the enabled edge on which each result must appear.
module tb_stage4_log2_approx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stage4_log2_approx_if bus();

   stage4_log2_approx dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [15:0] x;
      logic [15:0] lg;
      logic        inv;
      int          edge_n;
      bit          rt;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int failed = 0;
   int en_edges = 0;
   int pushed = 0;
   int popped = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference Mitchell log2 for the round-trip sweep.
   function automatic logic [15:0] ref_log(input logic [15:0] x);
      int k = 0;
      bit found = 0;
      int v;
      logic [5:0] ip;
      logic [9:0] mn;
      for (int b = 14; b >= 0; b--) begin
         if (!found && x[b]) begin
            k = b;
            found = 1;
         end
      end
      v  = int'(x[14:0]) << (14 - k);
      mn = 10'((v >> 4) & 1023);
      ip = 6'(k - 10);
      return {ip, mn};
   endfunction

   // Mitchell pow2 inverse, result in Q.10.
   function automatic int pow2_rec(input logic [15:0] l);
      int ip = $signed(l[15:10]);
      int fr = 1024 + int'(l[9:0]);
      if (ip >= 0) return fr << ip;
      return fr >>> (-ip);
   endfunction

   task automatic step(input logic en, input logic vld, input logic [15:0] x,
                       input logic [15:0] elog, input logic einv, input bit rt = 0);
      exp_t e;
      @(negedge clk);
      bus.i_en    = en;
      bus.i_valid = vld;
      bus.i_x     = x;
      if (en && vld) begin
         e.x = x; e.lg = elog; e.inv = einv; e.edge_n = en_edges + 3; e.rt = rt;
         sb.push_back(e);
         pushed++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0);
   endtask

   // Monitor: consumes a result only on enabled edges, as a downstream stage would.
   initial begin
      logic en_s, rst_s;
      exp_t e;
      int rec, diff;
      forever begin
         @(posedge clk);
         en_s  = bus.i_en;
         rst_s = rst;
         #1;
         if (!rst_s && !rst && en_s) begin
            en_edges++;
            if (bus.o_valid) begin
               tests++;
               assert (sb.size() != 0) else begin
                  failed++;
                  $error("FAIL unexpected_valid observed=o_valid@%0d expected=none x=%h",
                         en_edges, bus.o_x_bypass);
               end
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  popped++;
                  chk("log_x", 32'(bus.o_log_x), 32'(e.lg));
                  chk("invalid", 32'(bus.o_invalid), 32'(e.inv));
                  chk("bypass", 32'(bus.o_x_bypass), 32'(e.x));
                  chk("latency_edge", 32'(en_edges), 32'(e.edge_n));
                  if (e.rt) begin
                     rec  = pow2_rec(bus.o_log_x);
                     diff = rec - int'(e.x);
                     if (diff < 0) diff = -diff;
                     chk("roundtrip_6pct", 32'(diff * 100 <= 6 * int'(e.x)), 32'd1);
                  end
               end
            end
         end
      end
   end

   initial begin
      bus.i_en = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_x = 16'h0;
      #3;
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_log", 32'(bus.o_log_x), 32'd0);
      chk("rst_bypass", 32'(bus.o_x_bypass), 32'd0);
      chk("rst_invalid", 32'(bus.o_invalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Exact powers, back-to-back
      step(1, 1, 16'h0400, 16'h0000, 0);
      step(1, 1, 16'h0800, 16'h0400, 0);
      step(1, 1, 16'h1000, 16'h0800, 0);
      step(1, 1, 16'h0200, 16'hFC00, 0);
      // Mantissa and extremes
      step(1, 1, 16'h0600, 16'h0200, 0);
      step(1, 1, 16'h0A00, 16'h0500, 0);
      step(1, 1, 16'h0001, 16'hD800, 0);
      step(1, 1, 16'h7FFF, 16'h13FF, 0);
      // Invalid operands
      step(1, 1, 16'h0000, 16'h8000, 1);
      step(1, 1, 16'hF000, 16'h8000, 1);
      idle(5);
      chk("drain_after_directed", 32'(sb.size()), 32'd0);

      // Stall: frozen inputs toggle but must not be captured
      step(1, 1, 16'h0600, 16'h0200, 0);
      for (int i = 0; i < 4; i++)
         step(0, 1'(i % 2 == 0), 16'(16'h1234 + i), 16'h0, 0);
      idle(5);
      chk("stall_single_result", 32'(sb.size()), 32'd0);

      // Sparse valid: alternate cycles
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 16'(16'h0400 + 16'h0100 * i), ref_log(16'(16'h0400 + 16'h0100 * i)), 0);
         step(1, 0, 16'hFFFF, 16'h0, 0);
      end
      idle(4);

      // Round trip through the pow2 inverse
      for (int v = 16'h0400; v <= 16'h1000; v += 16'h0080)
         step(1, 1, 16'(v), ref_log(16'(v)), 0, 1);
      idle(5);
      chk("drain_after_sweep", 32'(sb.size()), 32'd0);

      // Reset with tokens in flight: A is at the output, B and C in flight
      step(1, 1, 16'h0400, 16'h0000, 0);
      step(1, 1, 16'h0800, 16'h0400, 0);
      step(1, 1, 16'h1000, 16'h0800, 0);
      @(posedge clk);
      #2;
      chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(bus.o_valid), 32'd0);
      chk("midrst_log", 32'(bus.o_log_x), 32'd0);
      chk("midrst_bypass", 32'(bus.o_x_bypass), 32'd0);
      chk("midrst_invalid", 32'(bus.o_invalid), 32'd0);
      sb.delete();
      bus.i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(6);
      step(1, 1, 16'h0A00, 16'h0500, 0);
      idle(5);
      chk("post_rst_drain", 32'(sb.size()), 32'd0);
      chk("post_rst_count", 32'(popped), 32'(pushed - 2));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
